// File: rtl/kbd_combo_matrix.sv
`default_nettype none
// ============================================================================
//  Module   : kbd_combo_matrix
//  Purpose  : Builds a ROWS x COLS pressed-key matrix for an emulated machine
//             keyboard from serialised key events. Direct events set or clear
//             a single matrix bit. Combo events drive NCOMBO "modifier + key"
//             chord channels: the modifier is asserted first and the key one
//             settle delay later. On release the key drops first and the
//             modifier follows one settle delay later.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1          system clock
//    reset      in   1          asynchronous, active-high reset
//    key_stb    in   1          one-cycle event strobe
//    key_press  in   1          1 = press, 0 = release
//    key_combo  in   1          1 = combo channel event, 0 = direct bit event
//    key_idx    in   IW         direct matrix index (row*COLS+col)
//    combo_id   in   CW         combo channel number
//    matrix     out  ROWS*COLS  registered pressed-key matrix (1 = pressed)
//    busy       out  1          registered, 1 while any channel is not idle
//    row_sel    in   ROWS       row strobe (KBD_ROW_READ_EN builds only)
//    col_out    out  COLS       OR of selected rows, registered
//                               (KBD_ROW_READ_EN builds only)
//  Build option
//    KBD_ROW_READ_EN  defined: adds the row_sel/col_out row-scan read port.
// ============================================================================
module kbd_combo_matrix #(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int NCOMBO   = 12,
    parameter int PRESCALE = 1024,
    parameter int SETTLE   = 15,
    localparam int IW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1,
    localparam int CW = (NCOMBO > 1) ? $clog2(NCOMBO) : 1,
    parameter logic [NCOMBO*IW-1:0] COMBO_MOD = '0,
    parameter logic [NCOMBO*IW-1:0] COMBO_KEY = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 key_stb,
    input  logic                 key_press,
    input  logic                 key_combo,
    input  logic [IW-1:0]        key_idx,
    input  logic [CW-1:0]        combo_id,
    output logic [ROWS*COLS-1:0] matrix,
    output logic                 busy
`ifdef KBD_ROW_READ_EN
    ,
    input  logic [ROWS-1:0]      row_sel,
    output logic [COLS-1:0]      col_out
`endif
);

    localparam int              c_nbits     = ROWS * COLS;
    localparam int              c_pw        = $clog2(PRESCALE);
    localparam logic [c_pw-1:0] c_pre_max   = c_pw'(PRESCALE - 1);
    localparam logic [IW:0]     c_nbits_w   = (IW + 1)'(c_nbits);
    localparam logic [7:0]      c_settle_m1 = 8'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MOD  = 2'd1,
        S_HOLD = 2'd2,
        S_REL  = 2'd3
    } state_t;

    logic [c_pw-1:0]    r_pre_cnt;
    logic               w_tick;
    logic [c_nbits-1:0] r_direct;
    logic [c_nbits-1:0] w_direct_nxt;
    logic [c_nbits-1:0] w_combo_bits;
    logic [c_nbits-1:0] r_matrix;
    logic               r_busy;
    logic [NCOMBO-1:0]  w_mod_on;
    logic [NCOMBO-1:0]  w_key_on;

    // ------------------------------------------------------------------
    // Delay-tick prescaler: one-cycle tick every PRESCALE clocks
    // ------------------------------------------------------------------
    assign w_tick = (r_pre_cnt == c_pre_max);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= w_tick ? '0 : r_pre_cnt + c_pw'(1);
        end
    end

    // ------------------------------------------------------------------
    // Direct bits. The next value feeds the matrix register so a direct
    // event is visible the cycle after its strobe.
    // ------------------------------------------------------------------
    always_comb begin
        w_direct_nxt = r_direct;
        if (key_stb && !key_combo && ({1'b0, key_idx} < c_nbits_w)) begin
            w_direct_nxt[key_idx] = key_press;
        end
    end

    // ------------------------------------------------------------------
    // Combo channels
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NCOMBO; g++) begin : g_ch
        state_t     r_state;
        state_t     w_state_nxt;
        logic [7:0] r_cnt;
        logic [7:0] w_cnt_nxt;
        logic       w_ev;

        // Ids with no channel behind them simply never match.
        assign w_ev = key_stb && key_combo && (combo_id == CW'(g));

        // An accepted event takes priority over a coincident tick, so the
        // count only advances when the state is not being redirected.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            case (r_state)
                S_IDLE: begin
                    if (w_ev && key_press) begin
                        w_state_nxt = S_MOD;
                        w_cnt_nxt   = 8'd0;
                    end
                end
                S_MOD: begin
                    if (w_ev && !key_press) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = 8'd0;
                    end else if (w_tick) begin
                        w_cnt_nxt = r_cnt + 8'd1;
                        if (r_cnt == c_settle_m1) begin
                            w_state_nxt = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_ev && !key_press) begin
                        w_state_nxt = S_REL;
                        w_cnt_nxt   = 8'd0;
                    end
                end
                S_REL: begin
                    // Re-press goes straight back to the lead phase; the
                    // modifier is driven in both states so it never gaps.
                    if (w_ev && key_press) begin
                        w_state_nxt = S_MOD;
                        w_cnt_nxt   = 8'd0;
                    end else if (w_tick) begin
                        w_cnt_nxt = r_cnt + 8'd1;
                        if (r_cnt == c_settle_m1) begin
                            w_state_nxt = S_IDLE;
                            w_cnt_nxt   = 8'd0;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 8'd0;
                end
            endcase
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_state <= S_IDLE;
                r_cnt   <= 8'd0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end

        assign w_mod_on[g] = (w_state_nxt != S_IDLE);
        assign w_key_on[g] = (w_state_nxt == S_HOLD);
    end

    // Overlapping channel bits and direct bits are simply OR'd together.
    always_comb begin
        w_combo_bits = '0;
        for (int i = 0; i < NCOMBO; i++) begin
            if (w_mod_on[i]) w_combo_bits[COMBO_MOD[i*IW +: IW]] = 1'b1;
            if (w_key_on[i]) w_combo_bits[COMBO_KEY[i*IW +: IW]] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_direct <= '0;
            r_matrix <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_direct <= w_direct_nxt;
            r_matrix <= w_direct_nxt | w_combo_bits;
            r_busy   <= |w_mod_on;
        end
    end

    assign matrix = r_matrix;
    assign busy   = r_busy;

`ifdef KBD_ROW_READ_EN
    // ------------------------------------------------------------------
    // Row-scan read port: columns of all selected rows OR'd together
    // ------------------------------------------------------------------
    logic [COLS-1:0] r_col;
    logic [COLS-1:0] w_col_nxt;

    always_comb begin
        w_col_nxt = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_sel[r]) begin
                w_col_nxt = w_col_nxt | r_matrix[r*COLS +: COLS];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col <= '0;
        end else begin
            r_col <= w_col_nxt;
        end
    end

    assign col_out = r_col;
`endif

endmodule
`default_nettype wire

// File: tb/tb_kbd_combo_matrix.sv
`default_nettype none
// ============================================================================
//  Module   : tb_kbd_combo_matrix
//  Purpose  : Self-checking bench for kbd_combo_matrix (8x8, 2 channels,
//             PRESCALE=4, SETTLE=3). A behavioural model tracks each chord
//             as a phase plus elapsed delay ticks and the absolute clock
//             count, and predicts matrix/busy (and col_out) every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_kbd_combo_matrix;

    localparam int P = 4;
    localparam int S = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        key_stb;
    logic        key_press;
    logic        key_combo;
    logic [5:0]  key_idx;
    logic [0:0]  combo_id;
    logic [63:0] matrix;
    logic        busy;
`ifdef KBD_ROW_READ_EN
    logic [7:0]  row_sel;
    logic [7:0]  col_out;
`endif

    always #5 clk = ~clk;

    kbd_combo_matrix #(
        .ROWS      (8),
        .COLS      (8),
        .NCOMBO    (2),
        .PRESCALE  (P),
        .SETTLE    (S),
        .COMBO_MOD ({6'd58, 6'd57}),
        .COMBO_KEY ({6'd12, 6'd9})
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .key_stb   (key_stb),
        .key_press (key_press),
        .key_combo (key_combo),
        .key_idx   (key_idx),
        .combo_id  (combo_id),
        .matrix    (matrix),
        .busy      (busy)
`ifdef KBD_ROW_READ_EN
        ,
        .row_sel   (row_sel),
        .col_out   (col_out)
`endif
    );

    // ---------------- reference model ----------------
    // phase: 0 = idle, 1 = modifier leading, 2 = chord held, 3 = modifier trailing
    int          m_phase [2];
    int          m_ticks [2];
    int          m_edges;
    bit [63:0]   m_direct;
    bit [63:0]   exp_matrix;
    bit          exp_busy;
    bit [7:0]    exp_col;
    int          mod_of [2] = '{57, 58};
    int          key_of [2] = '{9, 12};

    int          n_checks = 0;
    int          n_errors = 0;
    bit          watch57;
    bit          saw57_drop;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_direct   = '0;
        m_edges    = 0;
        exp_matrix = '0;
        exp_busy   = 1'b0;
        exp_col    = '0;
        for (int c = 0; c < 2; c++) begin
            m_phase[c] = 0;
            m_ticks[c] = 0;
        end
    endtask

    // Predicts the state right after the coming rising edge.
    task automatic model_step();
        bit tick;
        bit ev;
        tick = ((m_edges % P) == P - 1);
        m_edges++;
`ifdef KBD_ROW_READ_EN
        exp_col = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                if (row_sel[r] && exp_matrix[r*8+c]) exp_col[c] = 1'b1;
`endif
        if (key_stb && !key_combo) m_direct[key_idx] = key_press;
        for (int ch = 0; ch < 2; ch++) begin
            ev = key_stb && key_combo && (int'(combo_id) == ch);
            if (m_phase[ch] == 0) begin
                if (ev && key_press) begin m_phase[ch] = 1; m_ticks[ch] = 0; end
            end else if (m_phase[ch] == 1) begin
                if (ev && !key_press) m_phase[ch] = 0;
                else if (tick) begin
                    m_ticks[ch]++;
                    if (m_ticks[ch] == S) m_phase[ch] = 2;
                end
            end else if (m_phase[ch] == 2) begin
                if (ev && !key_press) begin m_phase[ch] = 3; m_ticks[ch] = 0; end
            end else begin
                if (ev && key_press) begin m_phase[ch] = 1; m_ticks[ch] = 0; end
                else if (tick) begin
                    m_ticks[ch]++;
                    if (m_ticks[ch] == S) m_phase[ch] = 0;
                end
            end
        end
        exp_matrix = m_direct;
        exp_busy   = 1'b0;
        for (int ch = 0; ch < 2; ch++) begin
            if (m_phase[ch] != 0) begin
                exp_matrix[mod_of[ch]] = 1'b1;
                exp_busy = 1'b1;
            end
            if (m_phase[ch] == 2) exp_matrix[key_of[ch]] = 1'b1;
        end
    endtask

    // One clock with the inputs currently driven; compare at the falling edge.
    task automatic cycle();
        model_step();
        @(negedge clk);
        check("matrix", matrix, exp_matrix);
        check("busy", {63'd0, busy}, {63'd0, exp_busy});
`ifdef KBD_ROW_READ_EN
        check("col_out", {56'd0, col_out}, {56'd0, exp_col});
`endif
        if (watch57 && !matrix[57]) saw57_drop = 1'b1;
    endtask

    task automatic idle(input int n);
        key_stb = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic ev_direct(input int idx, input bit press);
        key_stb = 1'b1; key_combo = 1'b0; key_idx = 6'(idx); key_press = press;
        cycle();
        key_stb = 1'b0;
    endtask

    task automatic ev_combo(input int id, input bit press);
        key_stb = 1'b1; key_combo = 1'b1; combo_id = 1'(id); key_press = press;
        cycle();
        key_stb = 1'b0;
    endtask

    // Cycles after the current point until matrix[bit_i]==val (bounded).
    task automatic wait_bit(input string tag, input int bit_i, input bit val, output int n);
        n = 0;
        while (matrix[bit_i] !== val && n < 40) begin
            idle(1);
            n++;
        end
        if (n >= 40) check({tag, "_timeout"}, 64'd1, 64'd0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        check("rst_matrix", matrix, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1; key_stb = 1'b0; key_press = 1'b0; key_combo = 1'b0;
        key_idx = '0; combo_id = '0; watch57 = 1'b0; saw57_drop = 1'b0;
`ifdef KBD_ROW_READ_EN
        row_sel = '0;
`endif
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_matrix", matrix, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
`ifdef KBD_ROW_READ_EN
        check("reset_col", {56'd0, col_out}, 64'd0);
`endif
        reset = 1'b0;
        idle(2);

        // Direct press / release, repeated press is idempotent
        ev_direct(33, 1'b1);
        check("d33_press", {63'd0, matrix[33]}, 64'd1);
        ev_direct(33, 1'b1);
        check("d33_repeat", {63'd0, matrix[33]}, 64'd1);
        ev_direct(33, 1'b0);
        check("d33_release", {63'd0, matrix[33]}, 64'd0);
        idle(2);

        // Chord ch0: modifier next cycle, key 9..12 cycles later
        ev_combo(0, 1'b1);
        check("c0_mod_first", {63'd0, matrix[57]}, 64'd1);
        check("c0_key_late", {63'd0, matrix[9]}, 64'd0);
        wait_bit("c0_hold", 9, 1'b1, n);
        check("c0_spacing_ok", {63'd0, (n >= 9 && n <= 12)}, 64'd1);
        check("c0_busy", {63'd0, busy}, 64'd1);
        ev_combo(0, 1'b1);   // typematic repeat, ignored
        idle(3);

        // Release in hold: key drops first, modifier trails
        ev_combo(0, 1'b0);
        check("c0_key_drop", {63'd0, matrix[9]}, 64'd0);
        check("c0_mod_trail", {63'd0, matrix[57]}, 64'd1);
        wait_bit("c0_rel", 57, 1'b0, n);
        check("c0_trail_ok", {63'd0, (n >= 8 && n <= 12)}, 64'd1);
        check("c0_idle_busy", {63'd0, busy}, 64'd0);

        // Release in the lead phase after exactly one tick
        ev_combo(0, 1'b1);
        idle(P);
        ev_combo(0, 1'b0);
        check("mod_abort_57", {63'd0, matrix[57]}, 64'd0);
        check("mod_abort_9", {63'd0, matrix[9]}, 64'd0);
        check("mod_abort_busy", {63'd0, busy}, 64'd0);
        idle(2);

        // Direct modifier overlapping a full chord cycle
        ev_direct(57, 1'b1);
        watch57 = 1'b1; saw57_drop = 1'b0;
        ev_combo(0, 1'b1);
        wait_bit("ovl_hold", 9, 1'b1, n);
        ev_combo(0, 1'b0);
        idle(16);
        check("ovl_57_held", {63'd0, saw57_drop}, 64'd0);
        watch57 = 1'b0;
        ev_direct(57, 1'b0);
        idle(1);

        // Re-press while the modifier is trailing: no gap, fresh lead delay
        ev_combo(0, 1'b1);
        wait_bit("rp_hold1", 9, 1'b1, n);
        ev_combo(0, 1'b0);
        watch57 = 1'b1; saw57_drop = 1'b0;
        idle(2);
        ev_combo(0, 1'b1);
        wait_bit("rp_hold2", 9, 1'b1, n);
        check("rp_spacing_ok", {63'd0, (n >= 8 && n <= 12)}, 64'd1);
        check("rp_no_gap", {63'd0, saw57_drop}, 64'd0);
        watch57 = 1'b0;
        ev_combo(0, 1'b0);
        wait_bit("rp_idle", 57, 1'b0, n);

        // Reset during ch1 hold
        ev_direct(20, 1'b1);
        ev_combo(1, 1'b1);
        wait_bit("c1_hold", 12, 1'b1, n);
        check("c1_mod", {63'd0, matrix[58]}, 64'd1);
        pulse_reset();
        idle(3);

`ifdef KBD_ROW_READ_EN
        ev_direct(9, 1'b1);
        row_sel = 8'h02;
        idle(1);
        check("row_read", {56'd0, col_out}, 64'h02);
        row_sel = 8'h00;
        idle(1);
        check("row_none", {56'd0, col_out}, 64'h00);
`endif

        // Randomised event stream checked against the model every cycle
        for (int i = 0; i < 1500; i++) begin
            int sel;
            key_stb = ($urandom_range(0, 2) == 0);
            key_combo = $urandom_range(0, 1);
            key_press = $urandom_range(0, 1);
            combo_id = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 5);
            case (sel)
                0: key_idx = 6'd57;
                1: key_idx = 6'd58;
                2: key_idx = 6'd9;
                3: key_idx = 6'd12;
                default: key_idx = 6'($urandom_range(0, 63));
            endcase
`ifdef KBD_ROW_READ_EN
            row_sel = 8'($urandom);
`endif
            cycle();
        end
        key_stb = 1'b0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
